mem_port_scheduler: RTL

- Sequential scheduler that shares the single-port unified instruction/data memory between the fetch stage and the load/store stage of the RV32I core.
- Memory side is a request/ready handshake with variable latency; the scheduler latches and holds each access until the memory completes it.
- It returns fetched instructions and load data to their requesters, drives stall_pc, enforces fetch anti-starvation, and has a watchdog timeout.

---
 rtl/mem_port_scheduler_if.sv | 61 ++++++
 rtl/mem_port_scheduler.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_scheduler_if.sv
// ----------------------------------------------------------------------------
// mem_port_scheduler_if
//   Bundles the signals between the shared-memory scheduler, its two
//   requesters (fetch stage, load/store stage) and the single-port memory.
//
//   Handshake semantics (one rule for every channel here):
//     - A requester raises if_req / d_req and holds it, with its fields
//       stable, until the matching one-cycle if_done / d_done pulse.
//     - The scheduler raises to_mem_req with stable to_mem_* fields and holds
//       them until a cycle in which from_mem_ready is 1; that cycle is the
//       completion of the access and from_mem_data is sampled then.
//
//   Modports:
//     slave  : scheduler view (requests and memory response in, results out)
//     master : environment view (requesters + memory model)
// ----------------------------------------------------------------------------
interface mem_port_scheduler_if;
   // fetch requester
   logic        if_req;
   logic [31:0] inst_addr;
   logic        ignore_curr_inst;
   logic        if_done;
   logic [31:0] instruction_code;
   // load/store requester
   logic        d_req;
   logic [31:0] mem_addr;
   logic        mem_rw_mode;
   logic [31:0] mem_write_data;
   logic [3:0]  mem_byte_en;
   logic        d_done;
   logic [31:0] mem_read_data;
   // status
   logic        bus_error;
   logic        stall_pc;
   // memory side
   logic        to_mem_req;
   logic [31:0] to_mem_addr;
   logic        to_mem_rw_mode;
   logic [31:0] to_mem_write_data;
   logic [3:0]  to_mem_byte_en;
   logic [31:0] from_mem_data;
   logic        from_mem_ready;

   modport slave (
      input  if_req, inst_addr, ignore_curr_inst,
      input  d_req, mem_addr, mem_rw_mode, mem_write_data, mem_byte_en,
      input  from_mem_data, from_mem_ready,
      output if_done, instruction_code, d_done, mem_read_data,
      output bus_error, stall_pc,
      output to_mem_req, to_mem_addr, to_mem_rw_mode, to_mem_write_data, to_mem_byte_en
   );

   modport master (
      output if_req, inst_addr, ignore_curr_inst,
      output d_req, mem_addr, mem_rw_mode, mem_write_data, mem_byte_en,
      output from_mem_data, from_mem_ready,
      input  if_done, instruction_code, d_done, mem_read_data,
      input  bus_error, stall_pc,
      input  to_mem_req, to_mem_addr, to_mem_rw_mode, to_mem_write_data, to_mem_byte_en
   );
endinterface

// File: rtl/mem_port_scheduler.sv
// ----------------------------------------------------------------------------
// mem_port_scheduler
//   Shares one single-port instruction/data memory between the fetch stage
//   and the load/store stage. Each access is granted from IDLE, latched into
//   to_mem_* and held until the memory signals ready (or the watchdog fires),
//   then the result is returned to its requester with a one-cycle done pulse.
//
//   Ports:
//     clk      : clock, rising edge
//     rst_n    : asynchronous active-low reset
//     bus      : mem_port_scheduler_if.slave (requesters + memory)
//     o_state  : current FSM state (0 IDLE, 1 FETCH_WAIT, 2 DATA_WAIT)
//
//   Parameters:
//     MAX_DATA_STREAK : data grants allowed in a row while fetch waits (1..15)
//     TIMEOUT         : wait-cycle limit before abort; 0 disables the watchdog
// ----------------------------------------------------------------------------
module mem_port_scheduler #(
   parameter int MAX_DATA_STREAK = 4,
   parameter int TIMEOUT         = 255
) (
   input  logic                   clk,
   input  logic                   rst_n,
   mem_port_scheduler_if.slave    bus,
   output logic [1:0]             o_state
);

   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      FETCH_WAIT = 2'd1,
      DATA_WAIT  = 2'd2
   } state_t;

   state_t        r_state;
   logic [3:0]    r_streak;
   logic [TW-1:0] r_tmo_cnt;
   logic          r_flush;

   logic          r_if_done;
   logic [31:0]   r_instruction_code;
   logic          r_d_done;
   logic [31:0]   r_mem_read_data;
   logic          r_bus_error;
   logic          r_to_mem_req;
   logic [31:0]   r_to_mem_addr;
   logic          r_to_mem_rw_mode;
   logic [31:0]   r_to_mem_write_data;
   logic [3:0]    r_to_mem_byte_en;

   logic          w_fetch_ok;
   logic          w_streak_full;
   logic          w_grant_d;
   logic          w_grant_f;
   logic          w_timeout;
   logic          w_drop_fetch;

   // A fetch flagged for flush in the same cycle it is requested is held back.
   assign w_fetch_ok    = bus.if_req & ~bus.ignore_curr_inst;
   assign w_streak_full = (r_streak == 4'(MAX_DATA_STREAK));
   // Data wins ties unless fetch has waited through a full streak of data grants.
   assign w_grant_d     = bus.d_req & ~(w_fetch_ok & w_streak_full);
   assign w_grant_f     = w_fetch_ok & ~w_grant_d;
   assign w_timeout     = (TIMEOUT != 0) && (r_tmo_cnt == TW'(TIMEOUT));
   // A flush arriving in the completion cycle itself also discards the word.
   assign w_drop_fetch  = r_flush | bus.ignore_curr_inst;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state             <= IDLE;
         r_streak            <= '0;
         r_tmo_cnt           <= '0;
         r_flush             <= 1'b0;
         r_if_done           <= 1'b0;
         r_instruction_code  <= '0;
         r_d_done            <= 1'b0;
         r_mem_read_data     <= '0;
         r_bus_error         <= 1'b0;
         r_to_mem_req        <= 1'b0;
         r_to_mem_addr       <= '0;
         r_to_mem_rw_mode    <= 1'b0;
         r_to_mem_write_data <= '0;
         r_to_mem_byte_en    <= '0;
      end else begin
         r_if_done   <= 1'b0;
         r_d_done    <= 1'b0;
         r_bus_error <= 1'b0;

         case (r_state)
            IDLE: begin
               r_tmo_cnt <= '0;
               r_flush   <= 1'b0;
               if (w_grant_d) begin
                  r_to_mem_req        <= 1'b1;
                  r_to_mem_addr       <= bus.mem_addr;
                  r_to_mem_rw_mode    <= bus.mem_rw_mode;
                  r_to_mem_write_data <= bus.mem_rw_mode ? 32'h0 : bus.mem_write_data;
                  r_to_mem_byte_en    <= bus.mem_rw_mode ? 4'h0 : bus.mem_byte_en;
                  r_state             <= DATA_WAIT;
                  // Streak only counts data grants that kept a fetch waiting.
                  if (!bus.if_req)
                     r_streak <= '0;
                  else if (!w_streak_full)
                     r_streak <= r_streak + 4'd1;
               end else if (w_grant_f) begin
                  r_to_mem_req        <= 1'b1;
                  r_to_mem_addr       <= bus.inst_addr;
                  r_to_mem_rw_mode    <= 1'b1;
                  r_to_mem_write_data <= 32'h0;
                  r_to_mem_byte_en    <= 4'h0;
                  r_state             <= FETCH_WAIT;
                  r_streak            <= '0;
               end
            end

            FETCH_WAIT: begin
               if (bus.ignore_curr_inst)
                  r_flush <= 1'b1;
               if (bus.from_mem_ready) begin
                  if (!w_drop_fetch) begin
                     r_if_done          <= 1'b1;
                     r_instruction_code <= bus.from_mem_data;
                  end
                  r_to_mem_req <= 1'b0;
                  r_tmo_cnt    <= '0;
                  r_flush      <= 1'b0;
                  r_state      <= IDLE;
               end else if (w_timeout) begin
                  r_bus_error  <= 1'b1;
                  r_if_done    <= ~w_drop_fetch;
                  r_to_mem_req <= 1'b0;
                  r_tmo_cnt    <= '0;
                  r_flush      <= 1'b0;
                  r_state      <= IDLE;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + TW'(1);
               end
            end

            DATA_WAIT: begin
               if (bus.from_mem_ready) begin
                  r_d_done <= 1'b1;
                  if (r_to_mem_rw_mode)
                     r_mem_read_data <= bus.from_mem_data;
                  r_to_mem_req <= 1'b0;
                  r_tmo_cnt    <= '0;
                  r_state      <= IDLE;
               end else if (w_timeout) begin
                  r_bus_error  <= 1'b1;
                  r_d_done     <= 1'b1;
                  r_to_mem_req <= 1'b0;
                  r_tmo_cnt    <= '0;
                  r_state      <= IDLE;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + TW'(1);
               end
            end

            default: begin
               r_to_mem_req <= 1'b0;
               r_state      <= IDLE;
            end
         endcase
      end
   end

   assign bus.if_done           = r_if_done;
   assign bus.instruction_code  = r_instruction_code;
   assign bus.d_done            = r_d_done;
   assign bus.mem_read_data     = r_mem_read_data;
   assign bus.bus_error         = r_bus_error;
   assign bus.to_mem_req        = r_to_mem_req;
   assign bus.to_mem_addr       = r_to_mem_addr;
   assign bus.to_mem_rw_mode    = r_to_mem_rw_mode;
   assign bus.to_mem_write_data = r_to_mem_write_data;
   assign bus.to_mem_byte_en    = r_to_mem_byte_en;

   // PC holds while data owns or is about to own the memory.
   assign bus.stall_pc = (r_state == DATA_WAIT)
                       | ((r_state == IDLE)       & bus.d_req)
                       | ((r_state == FETCH_WAIT) & bus.d_req);

   assign o_state = r_state;

endmodule
